// File: rtl/piano_key_if.sv
// Raw key inputs and selected note/octave/status outputs of the piano front end.
// The master side drives the raw keys; the slave side is the recorder.
interface piano_key_if #(
  parameter int NUM_KEYS    = 12,
  parameter int KEY_ID_BITS = 4
);
  logic [NUM_KEYS-1:0]    keys_in_raw;
  logic                   octave_up_raw;
  logic                   octave_down_raw;
  logic                   record_raw;
  logic                   playback_raw;
  logic [KEY_ID_BITS-1:0] key_id;
  logic                   key_is_pressed;
  logic                   octave_up;
  logic                   octave_down;
  logic                   is_recording;
  logic                   is_playing;

  modport master (
    output keys_in_raw, octave_up_raw, octave_down_raw, record_raw, playback_raw,
    input  key_id, key_is_pressed, octave_up, octave_down, is_recording, is_playing
  );

  modport slave (
    input  keys_in_raw, octave_up_raw, octave_down_raw, record_raw, playback_raw,
    output key_id, key_is_pressed, octave_up, octave_down, is_recording, is_playing
  );
endinterface

// File: rtl/piano_key_recorder.sv
// Debounces 12 note keys and 4 control keys, priority-encodes the note, and
// records/replays {octave, pressed, id} samples at a fixed interval.
module piano_key_recorder #(
  parameter int CLK_FREQ_HZ        = 50_000_000,
  parameter int DEBOUNCE_TIME_MS   = 20,
  parameter int NUM_KEYS           = 12,
  parameter int RECORD_INTERVAL_MS = 20,
  parameter int MAX_RECORD_SAMPLES = 512,
  parameter int KEY_ID_BITS        = 4,
  parameter int OCTAVE_BITS        = 2
) (
  input logic           clk,
  input logic           rst_n,
  piano_key_if.slave    bus
);

  localparam int DEBOUNCE_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_TIME_MS;
  localparam int INTERVAL_CYCLES = CLK_FREQ_HZ / 1000 * RECORD_INTERVAL_MS;
  localparam int NCH      = NUM_KEYS + 4;
  localparam int CH_UP    = NUM_KEYS;
  localparam int CH_DN    = NUM_KEYS + 1;
  localparam int CH_REC   = NUM_KEYS + 2;
  localparam int CH_PB    = NUM_KEYS + 3;
  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TICK_W   = $clog2(INTERVAL_CYCLES + 1);
  localparam int ADDR_W   = $clog2(MAX_RECORD_SAMPLES);
  localparam int LEN_W    = $clog2(MAX_RECORD_SAMPLES + 1);
  localparam int SAMPLE_W = OCTAVE_BITS + 1 + KEY_ID_BITS;

  localparam logic [DB_W-1:0]        DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TICK_W-1:0]      TICK_LAST = TICK_W'(INTERVAL_CYCLES - 1);
  localparam logic [LEN_W-1:0]       LEN_MAX   = LEN_W'(MAX_RECORD_SAMPLES);
  localparam logic [OCTAVE_BITS-1:0] OCT_UP    = OCTAVE_BITS'(1);
  localparam logic [OCTAVE_BITS-1:0] OCT_DN    = OCTAVE_BITS'(2);

  typedef enum logic [1:0] {IDLE, RECORDING, PLAYING} state_e;

  // ---------------- debounce ----------------
  logic [NCH-1:0]  raw_vec;
  logic [NCH-1:0]  sync1_q, sync2_q;
  logic [NCH-1:0]  db_q, db_d;
  logic [DB_W-1:0] cnt_q [NCH];
  logic [DB_W-1:0] cnt_d [NCH];

  assign raw_vec = {bus.playback_raw, bus.record_raw, bus.octave_down_raw,
                    bus.octave_up_raw, bus.keys_in_raw};

  // NOTE: combinational blocks use blocking '=' with a default for every output
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) db_d[i] = sync2_q[i];
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // NOTE: clocked state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw_vec;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // ---------------- scanner and live values ----------------
  logic [KEY_ID_BITS-1:0] live_id_q, live_id_d;
  logic                   live_pressed_q, live_pressed_d;
  logic                   pb_prev_q;
  logic                   pb_pulse, rec_lvl;
  logic [OCTAVE_BITS-1:0] live_oct_code;
  logic [SAMPLE_W-1:0]    sample_wr;

  // Descending scan so the lowest set index is the last to assign.
  always_comb begin
    live_id_d = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (db_q[i]) live_id_d = KEY_ID_BITS'(i + 1);
    end
    live_pressed_d = |db_q[NUM_KEYS-1:0];
  end

  always_comb begin
    case ({db_q[CH_UP], db_q[CH_DN]})
      2'b10:   live_oct_code = OCT_UP;
      2'b01:   live_oct_code = OCT_DN;
      default: live_oct_code = '0;
    endcase
  end

  assign pb_pulse  = db_q[CH_PB] & ~pb_prev_q;
  assign rec_lvl   = db_q[CH_REC];
  assign sample_wr = {live_oct_code, live_pressed_q, live_id_q};

  // ---------------- sample memory ----------------
  logic [SAMPLE_W-1:0] mem [MAX_RECORD_SAMPLES];
  logic                mem_we;
  logic [LEN_W-1:0]    rec_len_q, rec_len_d;
  logic [LEN_W-1:0]    rd_q, rd_d;
  logic [SAMPLE_W-1:0] rd_data;

  // NOTE: sample memory carries no reset; its contents are only read below rec_len.
  always_ff @(posedge clk) begin
    if (mem_we) mem[rec_len_q[ADDR_W-1:0]] <= sample_wr;
  end

  assign rd_data = mem[rd_d[ADDR_W-1:0]];

  // ---------------- control FSM ----------------
  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                rec_block_q, rec_block_d;
  logic                play_load;

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    rec_len_d   = rec_len_q;
    rd_d        = rd_q;
    rec_block_d = rec_block_q & rec_lvl;
    mem_we      = 1'b0;
    play_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rec_lvl && !rec_block_q) begin
          state_d   = RECORDING;
          tick_d    = '0;
          rec_len_d = '0;
        end else if (pb_pulse && rec_len_q != '0) begin
          state_d   = PLAYING;
          tick_d    = '0;
          rd_d      = '0;
          play_load = 1'b1;
        end
      end
      RECORDING: begin
        if (!rec_lvl) begin
          state_d = IDLE;
        end else begin
          tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
          if (tick_q == '0) begin
            mem_we    = 1'b1;
            rec_len_d = rec_len_q + 1'b1;
            // A full memory ends the take; the key must be released before re-arming.
            if (rec_len_d == LEN_MAX) begin
              state_d     = IDLE;
              rec_block_d = 1'b1;
            end
          end
        end
      end
      PLAYING: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (rd_q + 1'b1 == rec_len_q) begin
            state_d = IDLE;
          end else begin
            rd_d      = rd_q + 1'b1;
            play_load = 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- output registers ----------------
  logic [KEY_ID_BITS-1:0] key_id_q, key_id_d;
  logic                   pressed_q, pressed_d;
  logic                   oct_up_q, oct_up_d;
  logic                   oct_dn_q, oct_dn_d;

  // Outputs are loaded from the next state so playback data and status flags
  // appear on the same edge the state changes.
  always_comb begin
    key_id_d  = key_id_q;
    pressed_d = pressed_q;
    oct_up_d  = oct_up_q;
    oct_dn_d  = oct_dn_q;
    if (state_d == PLAYING) begin
      if (play_load) begin
        key_id_d  = rd_data[KEY_ID_BITS-1:0];
        pressed_d = rd_data[KEY_ID_BITS];
        oct_up_d  = (rd_data[SAMPLE_W-1 -: OCTAVE_BITS] == OCT_UP);
        oct_dn_d  = (rd_data[SAMPLE_W-1 -: OCTAVE_BITS] == OCT_DN);
      end
    end else begin
      key_id_d  = live_id_d;
      pressed_d = live_pressed_d;
      oct_up_d  = db_d[CH_UP];
      oct_dn_d  = db_d[CH_DN];
    end
  end

  logic is_rec_q, is_play_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      tick_q         <= '0;
      rec_len_q      <= '0;
      rd_q           <= '0;
      rec_block_q    <= 1'b0;
      live_id_q      <= '0;
      live_pressed_q <= 1'b0;
      pb_prev_q      <= 1'b0;
      key_id_q       <= '0;
      pressed_q      <= 1'b0;
      oct_up_q       <= 1'b0;
      oct_dn_q       <= 1'b0;
      is_rec_q       <= 1'b0;
      is_play_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick_d;
      rec_len_q      <= rec_len_d;
      rd_q           <= rd_d;
      rec_block_q    <= rec_block_d;
      live_id_q      <= live_id_d;
      live_pressed_q <= live_pressed_d;
      pb_prev_q      <= db_q[CH_PB];
      key_id_q       <= key_id_d;
      pressed_q      <= pressed_d;
      oct_up_q       <= oct_up_d;
      oct_dn_q       <= oct_dn_d;
      is_rec_q       <= (state_d == RECORDING);
      is_play_q      <= (state_d == PLAYING);
    end
  end

  assign bus.key_id         = key_id_q;
  assign bus.key_is_pressed = pressed_q;
  assign bus.octave_up      = oct_up_q;
  assign bus.octave_down    = oct_dn_q;
  assign bus.is_recording   = is_rec_q;
  assign bus.is_playing     = is_play_q;

endmodule

// File: tb/tb_piano_key_recorder.sv
// Directed test-plan scenarios plus randomized key activity, all compared each
// cycle against a queue/time-based reference model of the key recorder.
module tb_piano_key_recorder;

  localparam int NK   = 12;
  localparam int D    = 10;  // debounce cycles at 10 kHz / 1 ms
  localparam int I    = 10;  // sample interval cycles
  localparam int MAXS = 8;
  localparam int UP   = 12, DN = 13, REC = 14, PB = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  piano_key_if #(.NUM_KEYS(NK), .KEY_ID_BITS(4)) bus ();

  piano_key_recorder #(
    .CLK_FREQ_HZ(10_000), .DEBOUNCE_TIME_MS(1), .NUM_KEYS(NK),
    .RECORD_INTERVAL_MS(1), .MAX_RECORD_SAMPLES(MAXS),
    .KEY_ID_BITS(4), .OCTAVE_BITS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int id; bit pr; int oct;} sample_t;
  typedef enum {M_IDLE, M_REC, M_PLAY} mmode_e;

  sample_t    m_q[$];
  bit         m_s1[16], m_s2[16], m_db[16];
  int         m_mis[16];
  bit         m_pb_prev, m_blk, m_live_pr;
  int         m_live_id;
  mmode_e     m_mode;
  int         m_n = 0, m_rstart, m_pstart;
  logic [8:0] exp_vec;

  task automatic model_step();
    bit raw[16];
    bit db_old[16];
    int id_old;
    bit pr_old, pulse, recl;
    sample_t s;
    if (!rst_n) begin
      for (int c = 0; c < 16; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_db[c] = 0; m_mis[c] = 0;
      end
      m_pb_prev = 0; m_blk = 0; m_live_pr = 0; m_live_id = 0;
      m_mode = M_IDLE; m_q.delete();
      exp_vec = '0;
      m_n++;
      return;
    end
    for (int k = 0; k < NK; k++) raw[k] = bus.keys_in_raw[k];
    raw[UP] = bus.octave_up_raw; raw[DN] = bus.octave_down_raw;
    raw[REC] = bus.record_raw;   raw[PB] = bus.playback_raw;
    db_old = m_db;
    id_old = m_live_id;
    pr_old = m_live_pr;
    pulse  = m_db[PB] && !m_pb_prev;
    recl   = m_db[REC];

    case (m_mode)
      M_IDLE: begin
        if (recl && !m_blk) begin
          m_mode = M_REC; m_rstart = m_n + 1; m_q.delete();
        end else if (pulse && m_q.size() > 0) begin
          m_mode = M_PLAY; m_pstart = m_n;
        end
      end
      M_REC: begin
        if (!recl) m_mode = M_IDLE;
        else if ((m_n - m_rstart) % I == 0) begin
          s.id = id_old;
          s.pr = pr_old;
          s.oct = (db_old[UP] && !db_old[DN]) ? 1 : (db_old[DN] && !db_old[UP]) ? 2 : 0;
          m_q.push_back(s);
          if (m_q.size() == MAXS) begin m_mode = M_IDLE; m_blk = 1; end
        end
      end
      M_PLAY: if (m_n - m_pstart == m_q.size() * I) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
    if (!recl) m_blk = 0;

    // Output flips once the synced level has disagreed for D consecutive cycles.
    for (int c = 0; c < 16; c++) begin
      if (m_s2[c] != m_db[c]) begin
        m_mis[c]++;
        if (m_mis[c] == D) begin m_db[c] = m_s2[c]; m_mis[c] = 0; end
      end else m_mis[c] = 0;
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
    end

    m_live_id = 0;
    m_live_pr = 0;
    for (int k = 0; k < NK; k++) begin
      if (db_old[k] && m_live_id == 0) m_live_id = k + 1;
      if (db_old[k]) m_live_pr = 1;
    end
    m_pb_prev = db_old[PB];

    if (m_mode == M_PLAY) begin
      s = m_q[(m_n - m_pstart) / I];
      exp_vec = {4'(s.id), s.pr, s.oct == 1, s.oct == 2, 1'b0, 1'b1};
    end else begin
      exp_vec = {4'(m_live_id), m_live_pr, m_db[UP], m_db[DN], m_mode == M_REC, 1'b0};
    end
    m_n++;
  endtask

  // Per-cycle comparison and high-run measurement of the status flags.
  int rec_run = 0, last_rec_run = 0, play_run = 0, last_play_run = 0;

  always @(posedge clk) begin
    model_step();
    #2;
    check("cycle", {23'd0, bus.key_id, bus.key_is_pressed, bus.octave_up, bus.octave_down,
                    bus.is_recording, bus.is_playing}, {23'd0, exp_vec});
    if (bus.is_recording) rec_run++;
    else if (rec_run > 0) begin last_rec_run = rec_run; rec_run = 0; end
    if (bus.is_playing) play_run++;
    else if (play_run > 0) begin last_play_run = play_run; play_run = 0; end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_playing(input string tag, output int cycles);
    cycles = 0;
    while (!bus.is_playing && cycles < 40) begin
      tick(1);
      cycles++;
    end
    check(tag, {31'd0, bus.is_playing}, 32'd1);
  endtask

  task automatic never_plays(input string tag, input int k);
    logic seen;
    seen = 1'b0;
    for (int j = 0; j < k; j++) begin
      tick(1);
      seen = seen | bus.is_playing;
    end
    check(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.keys_in_raw = '0;
    bus.octave_up_raw = 0; bus.octave_down_raw = 0;
    bus.record_raw = 0; bus.playback_raw = 0;

    // Reset state
    tick(3);
    check("rst_key_id", {28'd0, bus.key_id}, 32'd0);
    check("rst_flags", {27'd0, bus.key_is_pressed, bus.octave_up, bus.octave_down,
                        bus.is_recording, bus.is_playing}, 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Bounce on key 2, then hold
    begin
      int pat[6] = '{3, 4, 7, 2, 9, 5};
      for (int j = 0; j < 6; j++) begin
        bus.keys_in_raw[2] = (j % 2 == 0);
        tick(pat[j]);
      end
    end
    check("bounce_rejected", {28'd0, bus.key_id}, 32'd0);
    bus.keys_in_raw[2] = 1'b1;
    cyc = 0;
    while (bus.key_id != 4'd3 && cyc < 30) begin
      tick(1);
      cyc++;
    end
    check("bounce_latency", cyc, 32'd13);
    check("bounce_pressed", {31'd0, bus.key_is_pressed}, 32'd1);

    // Priority
    bus.keys_in_raw = 12'b0010_0001_0000;
    tick(15);
    check("prio_4_9", {28'd0, bus.key_id}, 32'd5);
    bus.keys_in_raw[4] = 1'b0;
    tick(15);
    check("prio_9", {28'd0, bus.key_id}, 32'd10);
    bus.keys_in_raw = '0;
    tick(15);
    check("release_id", {28'd0, bus.key_id}, 32'd0);
    check("release_pressed", {31'd0, bus.key_is_pressed}, 32'd0);

    // Playback with empty memory
    bus.playback_raw = 1'b1;
    never_plays("empty_playback", 30);
    bus.playback_raw = 1'b0;
    tick(15);

    // Record 35 cycles: id 6 + octave up for the first 20, then nothing
    bus.keys_in_raw[5] = 1'b1;
    bus.octave_up_raw = 1'b1;
    tick(15);
    bus.record_raw = 1'b1;
    tick(20);
    bus.keys_in_raw = '0;
    bus.octave_up_raw = 1'b0;
    tick(15);
    bus.record_raw = 1'b0;
    tick(20);
    check("rec_len_35", last_rec_run, 32'd35);

    bus.playback_raw = 1'b1;
    wait_playing("play_start", cyc);
    check("play_latency", cyc, 32'd13);
    bus.playback_raw = 1'b0;
    check("play_s0_id", {28'd0, bus.key_id}, 32'd6);
    check("play_s0_up", {31'd0, bus.octave_up}, 32'd1);
    tick(19);
    check("play_c19_id", {28'd0, bus.key_id}, 32'd6);
    tick(1);
    check("play_c20_id", {28'd0, bus.key_id}, 32'd0);
    check("play_c20_up", {31'd0, bus.octave_up}, 32'd0);
    tick(19);
    check("play_c39", {31'd0, bus.is_playing}, 32'd1);
    tick(1);
    check("play_c40", {31'd0, bus.is_playing}, 32'd0);
    tick(2);
    check("play_len_40", last_play_run, 32'd40);

    // Full memory: record held 200 cycles with key 0 down
    bus.keys_in_raw[0] = 1'b1;
    tick(15);
    bus.record_raw = 1'b1;
    tick(200);
    bus.record_raw = 1'b0;
    tick(20);
    check("rec_full_run", last_rec_run, 32'd71);

    // Playback of full memory with a second press mid-playback
    bus.playback_raw = 1'b1;
    wait_playing("full_play_start", cyc);
    check("full_play_id", {28'd0, bus.key_id}, 32'd1);
    bus.playback_raw = 1'b0;
    tick(15);
    bus.playback_raw = 1'b1;
    tick(15);
    bus.playback_raw = 1'b0;
    cyc = 0;
    while (bus.is_playing && cyc < 120) begin
      tick(1);
      cyc++;
    end
    tick(2);
    check("full_play_len", last_play_run, 32'd80);
    bus.keys_in_raw = '0;
    tick(15);

    // Reset in the middle of playback
    bus.record_raw = 1'b1;
    tick(15);
    bus.record_raw = 1'b0;
    tick(20);
    bus.playback_raw = 1'b1;
    wait_playing("pre_reset_play", cyc);
    bus.playback_raw = 1'b0;
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_outs", {23'd0, bus.key_id, bus.key_is_pressed, bus.octave_up,
                             bus.octave_down, bus.is_recording, bus.is_playing}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    bus.playback_raw = 1'b1;
    never_plays("post_reset_playback", 30);
    bus.playback_raw = 1'b0;
    tick(15);

    // Randomized activity, compared cycle by cycle against the model
    for (int seg = 0; seg < 160; seg++) begin
      int r;
      r = $urandom_range(0, 3);
      if (r == 0)      bus.keys_in_raw = '0;
      else if (r == 1) bus.keys_in_raw = 12'(1 << $urandom_range(0, NK - 1));
      else             bus.keys_in_raw = 12'($urandom) & 12'($urandom);
      bus.octave_up_raw   = ($urandom_range(0, 2) == 0);
      bus.octave_down_raw = ($urandom_range(0, 2) == 0);
      bus.record_raw      = ($urandom_range(0, 3) == 0);
      bus.playback_raw    = ($urandom_range(0, 3) == 0);
      tick($urandom_range(1, 40));
    end
    bus.keys_in_raw = '0;
    bus.record_raw = 1'b0;
    bus.playback_raw = 1'b0;
    tick(120);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
